// File: rtl/bcd2bin_16_if.sv
// Handshake and data bundle between a decimal-entry front end and the BCD-to-binary converter.
// dbg_state mirrors the converter FSM so checkers can bind to it directly.
interface bcd2bin_16_if #(
    parameter int W    = 16,
    parameter int NDIG = 5
);
    logic                 start;
    logic [4*NDIG-1:0]    bcd_in;
    logic                 busy;
    logic                 done;
    logic [W-1:0]         bin;
    logic                 ovf;
    logic                 err;
    logic [1:0]           dbg_state;

    // start is sampled only while idle; done is a one-cycle pulse qualifying bin/ovf/err,
    // which then hold until the next completion. busy covers exactly the conversion cycles.
    modport master (
        output start, bcd_in,
        input  busy, done, bin, ovf, err, dbg_state
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin, ovf, err, dbg_state
    );
endinterface

// File: rtl/bcd2bin_16.sv
// Sequential BCD-to-binary converter: one decimal digit per clock via acc*10 + digit,
// with saturation on overflow and a fixed-latency invalid-digit flag.
module bcd2bin_16 #(
    parameter int W    = 16,
    parameter int NDIG = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2bin_16_if.slave  bus
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW = W + 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW-1:0] MAX_VAL = {{4{1'b0}}, {W{1'b1}}};

    logic [1:0]          state_q, state_d;
    logic [4*NDIG-1:0]   sr_q, sr_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bad_q, bad_d;
    logic                sat_q, sat_d;
    logic [W-1:0]        bin_q, bin_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    logic [3:0]          top_dig;
    logic [AW-1:0]       acc_nxt;
    logic                bad_in;

    always_comb begin
        top_dig = sr_q[4*NDIG-1 -: 4];
        acc_nxt = (acc_q << 3) + (acc_q << 1) + {{(AW-4){1'b0}}, top_dig};
        bad_in  = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        sat_d   = sat_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bcd_in;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    bad_d   = bad_in;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = CONV;
                end
            end
            CONV: begin
                // Once saturated, acc stays pinned so the remaining digits cannot wrap it.
                if (sat_q || (acc_nxt > MAX_VAL)) begin
                    acc_d = MAX_VAL;
                    sat_d = 1'b1;
                end else begin
                    acc_d = acc_nxt;
                end
                sr_d  = sr_q << 4;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (bad_q) begin
                        bin_d = '0;
                        err_d = 1'b1;
                        ovf_d = 1'b0;
                    end else begin
                        bin_d = acc_d[W-1:0];
                        err_d = 1'b0;
                        ovf_d = sat_d;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            sat_q   <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            sat_q   <= sat_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q == CONV);
    assign bus.done      = (state_q == DONE);
    assign bus.bin       = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bcd2bin_16.sv
// Directed bench for bcd2bin_16: boundary values, invalid digits, handshake timing,
// continuous start, input changes after capture and mid-conversion reset.
module tb_bcd2bin_16;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    bcd2bin_16_if #(.W(16), .NDIG(5)) bus ();

    bcd2bin_16 #(.W(16), .NDIG(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Pulse start for one cycle from IDLE; returns at the negedge of the done cycle
    // (or after a bounded wait). lat counts rising edges from acceptance to done, inclusive.
    task automatic run_conv(input logic [19:0] v, output int lat, output int bcnt);
        @(negedge clk);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(posedge clk);
        lat  = 1;
        bcnt = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        while (!bus.done && n < max_cyc) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    logic [19:0] vec_in  [9];
    logic [15:0] vec_bin [9];
    logic        vec_ovf [9];
    logic        vec_err [9];

    initial begin
        int lat, bcnt, n, dcount;
        int done_t[$];

        vec_in[0] = 20'h12345; vec_bin[0] = 16'h3039; vec_ovf[0] = 1'b0; vec_err[0] = 1'b0;
        vec_in[1] = 20'h65535; vec_bin[1] = 16'hFFFF; vec_ovf[1] = 1'b0; vec_err[1] = 1'b0;
        vec_in[2] = 20'h65536; vec_bin[2] = 16'hFFFF; vec_ovf[2] = 1'b1; vec_err[2] = 1'b0;
        vec_in[3] = 20'h99999; vec_bin[3] = 16'hFFFF; vec_ovf[3] = 1'b1; vec_err[3] = 1'b0;
        vec_in[4] = 20'h00000; vec_bin[4] = 16'h0000; vec_ovf[4] = 1'b0; vec_err[4] = 1'b0;
        vec_in[5] = 20'h1A345; vec_bin[5] = 16'h0000; vec_ovf[5] = 1'b0; vec_err[5] = 1'b1;
        vec_in[6] = 20'h9999A; vec_bin[6] = 16'h0000; vec_ovf[6] = 1'b0; vec_err[6] = 1'b1;
        vec_in[7] = 20'h00009; vec_bin[7] = 16'h0009; vec_ovf[7] = 1'b0; vec_err[7] = 1'b0;
        vec_in[8] = 20'h10000; vec_bin[8] = 16'h2710; vec_ovf[8] = 1'b0; vec_err[8] = 1'b0;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin",  32'(bus.bin),  32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_conv(vec_in[i], lat, bcnt);
            check($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
            check($sformatf("v%0d_lat", i),  32'(lat),      32'd6);
            check($sformatf("v%0d_busy", i), 32'(bcnt),     32'd5);
            check($sformatf("v%0d_busy_in_done", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_bin", i),  32'(bus.bin),  32'(vec_bin[i]));
            check($sformatf("v%0d_ovf", i),  32'(bus.ovf),  32'(vec_ovf[i]));
            check($sformatf("v%0d_err", i),  32'(bus.err),  32'(vec_err[i]));
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_hold", i),  32'(bus.bin),  32'(vec_bin[i]));
        end

        // Input changes after capture must not disturb the running conversion
        @(negedge clk);
        bus.bcd_in = 20'h00100;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("chg_busy", 32'(bus.busy), 32'd1);
        check("chg_hold_bin", 32'(bus.bin), 32'h2710);
        bus.bcd_in = 20'h00007;
        wait_done(10, n);
        check("chg_done", 32'(bus.done), 32'd1);
        check("chg_bin", 32'(bus.bin), 32'd100);
        @(negedge clk);

        // Continuous start: one conversion every NDIG+2 cycles, none accepted while busy/done
        bus.bcd_in = 20'h00042;
        bus.start  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                done_t.push_back(c);
                check("cont_bin", 32'(bus.bin), 32'd42);
                check("cont_busy_in_done", 32'(bus.busy), 32'd0);
            end
        end
        bus.start = 1'b0;
        check("cont_count", 32'(done_t.size()), 32'd4);
        if (done_t.size() > 0) check("cont_first", 32'(done_t[0]), 32'd6);
        for (int k = 1; k < done_t.size(); k++) begin
            check("cont_period", 32'(done_t[k] - done_t[k-1]), 32'd7);
        end
        repeat (8) @(negedge clk);

        // Reset three cycles into a conversion aborts it without a done pulse
        bus.bcd_in = 20'h12345;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy",  32'(bus.busy),      32'd0);
        check("abort_done",  32'(bus.done),      32'd0);
        check("abort_bin",   32'(bus.bin),       32'd0);
        check("abort_ovf",   32'(bus.ovf),       32'd0);
        check("abort_err",   32'(bus.err),       32'd0);
        check("abort_state", 32'(bus.dbg_state), 32'd0);
        dcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);

        run_conv(20'h00001, lat, bcnt);
        check("fresh_done", 32'(bus.done), 32'd1);
        check("fresh_lat",  32'(lat),      32'd6);
        check("fresh_bin",  32'(bus.bin),  32'd1);
        check("fresh_ovf",  32'(bus.ovf),  32'd0);
        check("fresh_err",  32'(bus.err),  32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
